wb_axi_bridge: RTL and testbench

WB_AXI_BRIDGE -- requirements
Module: wb_axi_bridge

---
 rtl/wb_axi_bridge_pkg.sv | 28 ++
 rtl/wb_axi_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_wb_axi_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_axi_bridge_pkg.sv
// ============================================================================
// Module  : wb_axi_bridge_pkg
// Brief   : Shared FSM encoding and window offsets for the Wishbone bridge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LW_ADDR = 3'd1,
        ST_LW_DATA = 3'd2,
        ST_LR_ADDR = 3'd3,
        ST_LR_DATA = 3'd4,
        ST_SS_PUSH = 3'd5,
        ST_SM_POP  = 3'd6,
        ST_ACK     = 3'd7
    } state_t;

    localparam logic [11:0] c_LITE_SPAN   = 12'h100;
    localparam logic [11:0] c_OFF_X_PUSH  = 12'h100;
    localparam logic [11:0] c_OFF_X_LAST  = 12'h104;
    localparam logic [11:0] c_OFF_Y_POP   = 12'h108;

endpackage

`default_nettype wire

// File: rtl/wb_axi_bridge.sv
// ============================================================================
// Module  : wb_axi_bridge
// Brief   : Wishbone slave window onto an AXI-Lite master and a FIR stream pair.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_axi_bridge
    import wb_axi_bridge_pkg::*;
#(
    parameter int          pADDR_WIDTH = 32,
    parameter int          pDATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    output logic                   ss_tvalid,
    input  logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    input  logic                   sm_tvalid,
    output logic                   sm_tready
);

    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d, ss_tdata_q, ss_tdata_d;
    logic                   ss_tlast_q, ss_tlast_d, y_last_q, y_last_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d, rready_q, rready_d;
    logic                   ss_tvalid_q, ss_tvalid_d, sm_tready_q, sm_tready_d;

    logic [11:0]            w_off;
    logic                   w_hit;
    logic                   w_unused;

    assign w_off    = wbs_adr_i[11:0];
    assign w_hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_unused = ^{wbs_sel_i, y_last_q};

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = dat_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        ss_tdata_d  = ss_tdata_q;
        ss_tlast_d  = ss_tlast_q;
        y_last_d    = y_last_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ss_tvalid_d = ss_tvalid_q;
        sm_tready_d = sm_tready_q;

        case (state_q)
            ST_IDLE: begin
                if (w_hit) begin
                    if (w_off < c_LITE_SPAN) begin
                        if (wbs_we_i) begin
                            awaddr_d  = pADDR_WIDTH'(w_off);
                            wdata_d   = pDATA_WIDTH'(wbs_dat_i);
                            awvalid_d = 1'b1;
                            state_d   = ST_LW_ADDR;
                        end else begin
                            araddr_d  = pADDR_WIDTH'(w_off);
                            arvalid_d = 1'b1;
                            state_d   = ST_LR_ADDR;
                        end
                    end else if (wbs_we_i && (w_off == c_OFF_X_PUSH || w_off == c_OFF_X_LAST)) begin
                        ss_tdata_d  = pDATA_WIDTH'(wbs_dat_i);
                        ss_tlast_d  = (w_off == c_OFF_X_LAST);
                        ss_tvalid_d = 1'b1;
                        state_d     = ST_SS_PUSH;
                    end else if (!wbs_we_i && w_off == c_OFF_Y_POP) begin
                        sm_tready_d = 1'b1;
                        state_d     = ST_SM_POP;
                    end else begin
                        // Unmapped offsets complete immediately; reads see zero.
                        if (!wbs_we_i) dat_d = '0;
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_LW_ADDR: if (awready) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                state_d   = ST_LW_DATA;
            end
            ST_LW_DATA: if (wready) begin
                wvalid_d = 1'b0;
                ack_d    = 1'b1;
                state_d  = ST_ACK;
            end
            ST_LR_ADDR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = ST_LR_DATA;
            end
            ST_LR_DATA: if (rvalid) begin
                rready_d = 1'b0;
                dat_d    = 32'(rdata);
                ack_d    = 1'b1;
                state_d  = ST_ACK;
            end
            ST_SS_PUSH: if (ss_tready) begin
                ss_tvalid_d = 1'b0;
                ack_d       = 1'b1;
                state_d     = ST_ACK;
            end
            ST_SM_POP: if (sm_tvalid) begin
                sm_tready_d = 1'b0;
                dat_d       = 32'(sm_tdata);
                y_last_d    = sm_tlast;
                ack_d       = 1'b1;
                state_d     = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            ss_tdata_q  <= '0;
            ss_tlast_q  <= 1'b0;
            y_last_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ss_tvalid_q <= 1'b0;
            sm_tready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            ss_tdata_q  <= ss_tdata_d;
            ss_tlast_q  <= ss_tlast_d;
            y_last_q    <= y_last_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ss_tvalid_q <= ss_tvalid_d;
            sm_tready_q <= sm_tready_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wvalid    = wvalid_q;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ss_tdata  = ss_tdata_q;
    assign ss_tlast  = ss_tlast_q;
    assign ss_tvalid = ss_tvalid_q;
    assign sm_tready = sm_tready_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_axi_bridge.sv
// ============================================================================
// Module  : tb_wb_axi_bridge
// Brief   : Self-checking bench for wb_axi_bridge with responder-side models.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_axi_bridge;
    import wb_axi_bridge_pkg::*;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] awaddr, wdata, araddr, ss_tdata;
    logic        awvalid, wvalid, arvalid, rready, ss_tlast, ss_tvalid, sm_tready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic        ss_tready = 1'b0, sm_tvalid = 1'b0, sm_tlast = 1'b0;
    logic [31:0] rdata = '0, sm_tdata = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_read = '0;

    wb_axi_bridge dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
        .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_responders();
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
        ss_tready = 1'b0; sm_tvalid = 1'b0;
    endtask

    // One Wishbone cycle; the bench plays AXI-Lite slave and FIR on both streams.
    // dly_a: ready delay for AW/AR/TX/RX channels, dly_b: W ready or R valid delay.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input int dly_a, input int dly_b, input logic [31:0] rsp,
                           input logic rsp_last, input bit drop_stb);
        logic [11:0] off;
        bit          in_win, k_lw, k_lr, k_push, k_pop, k_dummy, exp_ack;
        logic [31:0] exp_dat;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, ss_cnt = 0, sm_cnt = 0;
        int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, ss_n = 0, sm_n = 0;
        int r_wait = 0, last_hs = -1, ack_cyc = -1, bad = 0, multi = 0, budget;
        bit r_pending = 0, ack_seen = 0;
        logic [31:0] ack_dat = '0;

        off     = adr[11:0];
        in_win  = (adr[31:12] == 20'h30000);
        k_lw    = in_win && we && off < 12'h100;
        k_lr    = in_win && !we && off < 12'h100;
        k_push  = in_win && we && (off == 12'h100 || off == 12'h104);
        k_pop   = in_win && !we && off == 12'h108;
        k_dummy = in_win && !(k_lw || k_lr || k_push || k_pop);
        exp_ack = in_win;
        if (k_lr || k_pop)    exp_dat = rsp;
        else if (k_dummy && !we) exp_dat = 32'h0;
        else                  exp_dat = last_read;
        budget = exp_ack ? 80 : 20;

        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;

        for (int c = 0; c < budget && !ack_seen; c++) begin
            @(negedge axis_clk);
            if (32'(awvalid) + 32'(wvalid) + 32'(arvalid) + 32'(ss_tvalid) + 32'(sm_tready) > 1)
                multi++;
            if (wbs_ack_o) begin
                ack_seen = 1; ack_cyc = c; ack_dat = wbs_dat_o;
                if (k_lw && (awaddr !== 32'(off) || wdata !== wdat)) bad++;
                if (k_lr && araddr !== 32'(off)) bad++;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                clear_responders();
            end else begin
                if (drop_stb && c == 1) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
                awready = awvalid && aw_cnt == dly_a;
                if (awvalid) begin aw_cnt++; if (awaddr !== 32'(off) || wdata !== wdat) bad++; end
                if (awready) begin aw_n++; last_hs = c; end
                wready = wvalid && w_cnt == dly_b;
                if (wvalid) begin w_cnt++; if (wdata !== wdat || awaddr !== 32'(off)) bad++; end
                if (wready) begin w_n++; last_hs = c; end
                rvalid = rready && r_pending && r_wait == dly_b;
                if (rready && r_pending) r_wait++;
                if (rvalid) begin rdata = rsp; r_n++; r_pending = 0; last_hs = c; end
                if (rready && araddr !== 32'(off)) bad++;
                arready = arvalid && ar_cnt == dly_a;
                if (arvalid) begin ar_cnt++; if (araddr !== 32'(off)) bad++; end
                if (arready) begin ar_n++; r_pending = 1; r_wait = 0; last_hs = c; end
                ss_tready = ss_tvalid && ss_cnt == dly_a;
                if (ss_tvalid) begin
                    ss_cnt++;
                    if (ss_tdata !== wdat || ss_tlast !== (off == 12'h104)) bad++;
                end
                if (ss_tready) begin ss_n++; last_hs = c; end
                sm_tvalid = sm_tready && sm_cnt == dly_a;
                if (sm_tready) sm_cnt++;
                if (sm_tvalid) begin sm_tdata = rsp; sm_tlast = rsp_last; sm_n++; last_hs = c; end
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        clear_responders();

        chk("ack_seen", 32'(ack_seen), 32'(exp_ack));
        chk("aw_valid_cycles", 32'(aw_cnt), k_lw ? 32'(dly_a + 1) : 32'd0);
        chk("w_valid_cycles",  32'(w_cnt),  k_lw ? 32'(dly_b + 1) : 32'd0);
        chk("ar_valid_cycles", 32'(ar_cnt), k_lr ? 32'(dly_a + 1) : 32'd0);
        chk("r_beats",         32'(r_n),    k_lr ? 32'd1 : 32'd0);
        chk("ss_valid_cycles", 32'(ss_cnt), k_push ? 32'(dly_a + 1) : 32'd0);
        chk("sm_ready_cycles", 32'(sm_cnt), k_pop ? 32'(dly_a + 1) : 32'd0);
        chk("hs_counts", 32'(aw_n + w_n + ar_n + ss_n + sm_n),
            32'(2 * int'(k_lw) + int'(k_lr) + int'(k_push) + int'(k_pop)));
        chk("payload_stable", 32'(bad), 32'd0);
        chk("one_hot_valids", 32'(multi), 32'd0);
        if (exp_ack) begin
            chk("ack_latency", 32'(ack_cyc - last_hs), 32'd1);
            chk("ack_data", ack_dat, exp_dat);
            if (k_pop) chk("y_last", 32'(dut.y_last_q), 32'(rsp_last));
            last_read = exp_dat;
        end
        @(negedge axis_clk);
        chk("ack_single_cycle", 32'(wbs_ack_o), 32'd0);
    endtask

    initial begin
        logic [31:0] adr;
        int          sel;
        bit          seen_w;

        repeat (3) @(negedge axis_clk);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, ss_tlast}), 32'd0);
        chk("rst_dat_o", wbs_dat_o, 32'd0);
        chk("rst_addrs", awaddr | araddr, 32'd0);
        chk("rst_data", wdata | ss_tdata, 32'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        wb_xfer(1'b1, 32'h3000_0010, 32'd64,        1, 2,  32'h0,         1'b0, 1'b0);
        wb_xfer(1'b0, 32'h3000_0040, 32'h0,         0, 3,  32'hFFFF_FFF6, 1'b0, 1'b0);
        wb_xfer(1'b1, 32'h3000_0104, 32'd7,         5, 0,  32'h0,         1'b0, 1'b0);
        wb_xfer(1'b0, 32'h3000_0108, 32'h0,         10, 0, 32'h0000_0123, 1'b1, 1'b0);
        wb_xfer(1'b0, 32'h3000_0200, 32'h0,         0, 0,  32'h0,         1'b0, 1'b0);
        wb_xfer(1'b0, 32'h3100_0000, 32'h0,         0, 0,  32'h0,         1'b0, 1'b0);
        wb_xfer(1'b1, 32'h3000_00F0, 32'hA5A5_0001, 3, 3,  32'h0,         1'b0, 1'b1);

        // Abort a write while it waits in the W phase.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'h0000_BEEF;
        seen_w = 0;
        for (int c = 0; c < 10 && !seen_w; c++) begin
            @(negedge axis_clk);
            awready = awvalid;
            seen_w  = wvalid;
        end
        chk("abort_reached_w", 32'(seen_w), 32'd1);
        awready = 1'b0;
        @(negedge axis_clk);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        chk("abort_valids", 32'({awvalid, wvalid}), 32'd0);
        chk("abort_ack", 32'(wbs_ack_o), 32'd0);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        axis_rst_n = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        last_read = '0;
        @(negedge axis_clk);
        chk("abort_no_late_ack", 32'(wbs_ack_o), 32'd0);
        wb_xfer(1'b1, 32'h3000_0024, 32'h0000_1234, 0, 1, 32'h0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 5: adr = 32'h3000_0000 | ($urandom_range(0, 63) << 2);
                1:    adr = ($urandom_range(0, 1) == 0) ? 32'h3000_0100 : 32'h3000_0104;
                2:    adr = 32'h3000_0108;
                3:    adr = 32'h3000_0000 | ($urandom_range(32'h43, 32'h3FF) << 2);
                default: adr = ($urandom_range(0, 1) == 0) ? (32'h3100_0000 | $urandom_range(0, 255))
                                                           : 32'h2FFF_F000;
            endcase
            wb_xfer(1'($urandom_range(0, 1)), adr, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
